// File: rtl/lstm_cell_sequencer_if.sv
// Request/result handshake bundle between the gate-memory reader, the sequencer and h/c write-back.
// `LSTM_SEQ_LAST_EN adds out_last to the result side.
interface lstm_cell_sequencer_if #(
  parameter int WL = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [4*WL-1:0] gate_in;
  logic [WL-1:0]   c_in;
  logic            out_valid;
  logic            out_ready;
  logic [WL-1:0]   h_out;
  logic [WL-1:0]   c_out;
`ifdef LSTM_SEQ_LAST_EN
  logic            out_last;

  modport master (
    output in_valid, gate_in, c_in, out_ready,
    input  in_ready, out_valid, h_out, c_out, out_last
  );

  modport slave (
    input  in_valid, gate_in, c_in, out_ready,
    output in_ready, out_valid, h_out, c_out, out_last
  );
`else
  modport master (
    output in_valid, gate_in, c_in, out_ready,
    input  in_ready, out_valid, h_out, c_out
  );

  modport slave (
    input  in_valid, gate_in, c_in, out_ready,
    output in_ready, out_valid, h_out, c_out
  );
`endif
endinterface

// File: rtl/lstm_cell_sequencer.sv
// Schedules one LSTM hidden element through the shared sigmoid/tanh/mult/accum datapath.
// Optional `LSTM_SEQ_LAST_EN: out_last flag driven by a per-timestep element counter.
//
// state  | meaning
// IDLE   | in_ready high, waiting for an element
// FC     | cycle 0: sigmoid(f) times delayed c_pre
// IG     | cycle 1: sigmoid(i) times tanh(g)
// WAIT_C | products drain; accumulator cleared once at T_H-1
// OT     | cycle T_C: sigmoid(o) times tanh(c_new), c_out captured
// WAIT_H | waits for h_new at T_C+T_H
// OUT    | result held on out_valid until out_ready
module lstm_cell_sequencer #(
  parameter int WL      = 16,
  parameter int LAT_ACT = 2,
  parameter int LAT_MUL = 3,
  parameter int LAT_ACC = 1,
  parameter int N_CELL  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  lstm_cell_sequencer_if.slave bus,
  output logic [WL-1:0]        o_mem_net1,
  output logic [WL-1:0]        o_mem_net2,
  output logic [WL-1:0]        o_c_pre,
  output logic                 o_mux_c_gate_sel,
  output logic                 o_mux_c_tanh_sel,
  output logic                 o_accum_rst,
  input  logic [WL-1:0]        i_h_new,
  input  logic [WL-1:0]        i_c_new
);

  localparam int T_C = LAT_ACT + LAT_MUL + LAT_ACC + 1;
  localparam int T_H = LAT_ACT + LAT_MUL;
  localparam int CW  = $clog2(T_C + T_H + 1);

  // Counter holds T_C-1-k during cycle k; the clear is issued one cycle ahead of T_H-1.
  localparam logic [CW-1:0] C_FC_LOAD = CW'(T_C - 1);
  localparam logic [CW-1:0] C_CLR_AT  = CW'(T_C - T_H + 1);
  localparam logic [CW-1:0] C_OT_LOAD = CW'(T_H);

  typedef enum logic [2:0] {
    S_IDLE, S_FC, S_IG, S_WAIT_C, S_OT, S_WAIT_H, S_OUT
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [WL-1:0]   r_gate_i;
  logic [WL-1:0]   r_gate_g;
  logic [WL-1:0]   r_gate_o;
  logic            r_in_ready;
  logic [WL-1:0]   r_mem_net1;
  logic [WL-1:0]   r_mem_net2;
  logic [WL-1:0]   r_c_pre;
  logic            r_gate_sel;
  logic            r_tanh_sel;
  logic            r_accum_clr;
  logic            r_out_valid;
  logic [WL-1:0]   r_h_out;
  logic [WL-1:0]   r_c_out;

`ifdef LSTM_SEQ_LAST_EN
  localparam int NC_W = (N_CELL > 1) ? $clog2(N_CELL) : 1;
  logic [NC_W-1:0] r_elem_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_elem_cnt <= '0;
    end else if (r_state == S_OUT && bus.out_ready) begin
      r_elem_cnt <= (r_elem_cnt == NC_W'(N_CELL - 1)) ? '0 : r_elem_cnt + 1'b1;
    end
  end

  assign bus.out_last = r_out_valid && (r_elem_cnt == NC_W'(N_CELL - 1));
`else
  logic w_unused_ncell;
  assign w_unused_ncell = (N_CELL > 0);
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_gate_i    <= '0;
      r_gate_g    <= '0;
      r_gate_o    <= '0;
      r_in_ready  <= 1'b0;
      r_mem_net1  <= '0;
      r_mem_net2  <= '0;
      r_c_pre     <= '0;
      r_gate_sel  <= 1'b0;
      r_tanh_sel  <= 1'b0;
      r_accum_clr <= 1'b0;
      r_out_valid <= 1'b0;
      r_h_out     <= '0;
      r_c_out     <= '0;
    end else begin
      r_accum_clr <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_in_ready) begin
            r_in_ready <= 1'b1;
          end else if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            r_gate_i   <= bus.gate_in[WL-1:0];
            r_gate_g   <= bus.gate_in[3*WL-1:2*WL];
            r_gate_o   <= bus.gate_in[4*WL-1:3*WL];
            r_mem_net1 <= bus.gate_in[2*WL-1:WL];
            r_mem_net2 <= '0;
            r_c_pre    <= bus.c_in;
            r_tanh_sel <= 1'b1;
            r_gate_sel <= 1'b0;
            r_cnt      <= C_FC_LOAD;
            r_state    <= S_FC;
          end
        end
        S_FC: begin
          r_mem_net1 <= r_gate_i;
          r_mem_net2 <= r_gate_g;
          r_tanh_sel <= 1'b0;
          r_cnt      <= r_cnt - 1'b1;
          r_state    <= S_IG;
        end
        S_IG: begin
          r_mem_net1 <= '0;
          r_mem_net2 <= '0;
          if (r_cnt == C_CLR_AT) r_accum_clr <= 1'b1;
          r_cnt      <= r_cnt - 1'b1;
          r_state    <= S_WAIT_C;
        end
        S_WAIT_C: begin
          if (r_cnt == C_CLR_AT) r_accum_clr <= 1'b1;
          if (r_cnt == '0) begin
            r_mem_net1 <= r_gate_o;
            r_gate_sel <= 1'b1;
            r_cnt      <= C_OT_LOAD;
            r_state    <= S_OT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_OT: begin
          r_c_out    <= i_c_new;
          r_mem_net1 <= '0;
          r_gate_sel <= 1'b0;
          r_cnt      <= r_cnt - 1'b1;
          r_state    <= S_WAIT_H;
        end
        S_WAIT_H: begin
          if (r_cnt == '0) begin
            r_h_out     <= i_h_new;
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.h_out       = r_h_out;
  assign bus.c_out       = r_c_out;
  assign o_mem_net1      = r_mem_net1;
  assign o_mem_net2      = r_mem_net2;
  assign o_c_pre         = r_c_pre;
  assign o_mux_c_gate_sel = r_gate_sel;
  assign o_mux_c_tanh_sel = r_tanh_sel;
  assign o_accum_rst     = r_accum_clr | i_rst;

endmodule

// File: tb/tb_lstm_cell_sequencer.sv
// Bench for lstm_cell_sequencer: behavioural Q8.8 datapath plus an arithmetic result/schedule model.
module tb_lstm_cell_sequencer;
  localparam int WL      = 16;
  localparam int LAT_ACT = 2;
  localparam int LAT_MUL = 3;
  localparam int LAT_ACC = 1;
  localparam int N_CELL  = 4;
  localparam int T_C     = LAT_ACT + LAT_MUL + LAT_ACC + 1;
  localparam int T_H     = LAT_ACT + LAT_MUL;
  localparam int LATENCY = T_C + T_H + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lstm_cell_sequencer_if #(.WL(WL)) bus ();
  logic [WL-1:0] mem_net1, mem_net2, c_pre, h_new, c_new;
  logic gsel, tsel, accum_rst;

  lstm_cell_sequencer #(
    .WL(WL), .LAT_ACT(LAT_ACT), .LAT_MUL(LAT_MUL), .LAT_ACC(LAT_ACC), .N_CELL(N_CELL)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .o_mem_net1(mem_net1), .o_mem_net2(mem_net2), .o_c_pre(c_pre),
    .o_mux_c_gate_sel(gsel), .o_mux_c_tanh_sel(tsel), .o_accum_rst(accum_rst),
    .i_h_new(h_new), .i_c_new(c_new)
  );

  // Q8.8 arithmetic: hard sigmoid, clipped tanh, truncating multiply
  function automatic logic [15:0] f_sig(input logic [15:0] x);
    int y;
    y = 128 + (int'($signed(x)) >>> 2);
    if (y < 0) y = 0;
    if (y > 256) y = 256;
    return 16'(y);
  endfunction

  function automatic logic [15:0] f_tanh(input logic [15:0] x);
    int y;
    y = int'($signed(x));
    if (y < -256) y = -256;
    if (y > 256) y = 256;
    return 16'(y);
  endfunction

  function automatic logic [15:0] f_mul(input logic [15:0] a, input logic [15:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 16'(p >>> 8);
  endfunction

  function automatic logic [31:0] model_hc(input logic [15:0] f, i, g, o, cin);
    logic [15:0] c, h;
    c = f_mul(f_sig(f), cin) + f_mul(f_sig(i), f_tanh(g));
    h = f_mul(f_sig(o), f_tanh(c));
    return {h, c};
  endfunction

  // cycle-accurate datapath: act latency 2, mult 3, accum 1, c_pre and its select delayed 2
  logic [WL-1:0] sg1, sg2, th1, th2, cp1, cp2, p1, p2, p3, acc;
  logic ts1, ts2;
  wire [WL-1:0] w_tanh_in = gsel ? c_new : mem_net2;
  wire [WL-1:0] w_mul_b   = ts2 ? cp2 : th2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sg1 <= '0; sg2 <= '0; th1 <= '0; th2 <= '0; cp1 <= '0; cp2 <= '0;
      p1 <= '0; p2 <= '0; p3 <= '0; acc <= '0; ts1 <= 1'b0; ts2 <= 1'b0;
    end else begin
      sg1 <= f_sig(mem_net1); sg2 <= sg1;
      th1 <= f_tanh(w_tanh_in); th2 <= th1;
      cp1 <= c_pre; cp2 <= cp1; ts1 <= tsel; ts2 <= ts1;
      p1 <= f_mul(sg2, w_mul_b); p2 <= p1; p3 <= p2;
      acc <= accum_rst ? '0 : acc + p3;
    end
  end
  assign h_new = p3;
  assign c_new = acc;

  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at cycle-time %0t", nm, got, exp, $time);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] q_c[$], q_h[$];
  int q_a[$];
  bit act = 0, ov_prev = 0, rdy_chk = 0;
  int a_cyc = 0, acc_n = 0, res_n = 0, stall = 0, last_stall = 0, first_lat = 0, last_lat = 0;
  int since_rst = 0, n_last = 0;
  logic [15:0] e_f, e_i, e_g, e_o, e_cin, hold_c, hold_h, last_c, last_h;
  logic [31:0] last_mask = '0;

  always @(negedge clk) begin
    int k;
    logic [31:0] hc;
    if (rst) begin
      act = 0; ov_prev = 0; rdy_chk = 0; since_rst = 0;
      q_c.delete(); q_h.delete(); q_a.delete();
      chk("rst_accum_rst", accum_rst, 1);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_in_ready", bus.in_ready, 0);
    end else begin
      if (rdy_chk) begin
        chk("in_ready_after_accept", bus.in_ready, 1);
        rdy_chk = 0;
      end
      if (act) begin
        k = cyc - a_cyc - 1;
        if (k >= 0 && k <= T_C + T_H) begin
          chk("accum_rst_sched", accum_rst, (k == T_H - 1));
          chk("tanh_sel_sched", tsel, (k == 0));
          chk("gate_sel_sched", gsel, (k == T_C));
          chk("mem_net1_sched", mem_net1,
              (k == 0) ? e_f : (k == 1) ? e_i : (k == T_C) ? e_o : 16'h0);
          if (k < T_C) chk("mem_net2_sched", mem_net2, (k == 1) ? e_g : 16'h0);
          chk("c_pre_held", c_pre, e_cin);
        end
        chk("in_ready_busy", bus.in_ready, 0);
      end
      if (bus.out_valid) begin
        if (!ov_prev) begin
          if (q_c.size() == 0) begin
            chk("unexpected_out_valid", bus.out_valid, 0);
          end else begin
            first_lat = cyc - q_a[0];
            chk("latency", first_lat, LATENCY);
            chk("c_out", bus.c_out, q_c[0]);
            chk("h_out", bus.h_out, q_h[0]);
          end
          hold_c = bus.c_out; hold_h = bus.h_out; stall = 0;
        end else begin
          chk("hold_c_out", bus.c_out, hold_c);
          chk("hold_h_out", bus.h_out, hold_h);
        end
        stall++;
`ifdef LSTM_SEQ_LAST_EN
        chk("out_last", bus.out_last, ((since_rst % N_CELL) == N_CELL - 1));
`endif
        if (bus.out_ready) begin
`ifdef LSTM_SEQ_LAST_EN
          if (bus.out_last) begin
            n_last++;
            last_mask[since_rst] = 1'b1;
          end
`endif
          if (q_c.size() > 0) begin
            void'(q_c.pop_front()); void'(q_h.pop_front()); void'(q_a.pop_front());
          end
          res_n++; since_rst++;
          last_c = bus.c_out; last_h = bus.h_out; last_stall = stall; last_lat = first_lat;
          act = 0; rdy_chk = 1;
        end
      end
      ov_prev = bus.out_valid && !bus.out_ready;
      if (bus.in_valid && bus.in_ready) begin
        e_i = bus.gate_in[15:0];  e_f = bus.gate_in[31:16];
        e_g = bus.gate_in[47:32]; e_o = bus.gate_in[63:48];
        e_cin = bus.c_in;
        hc = model_hc(e_f, e_i, e_g, e_o, e_cin);
        q_c.push_back(hc[15:0]); q_h.push_back(hc[31:16]); q_a.push_back(cyc);
        a_cyc = cyc; act = 1; acc_n++;
      end
    end
  end

  task automatic send(input logic [15:0] f, i, g, o, cin, input bit drop);
    int n0;
    bit got;
    n0 = acc_n; got = 0;
    bus.gate_in = {o, g, f, i}; bus.c_in = cin; bus.in_valid = 1'b1;
    for (int t = 0; t < 60; t++) begin
      @(posedge clk);
      if (acc_n != n0) begin got = 1; break; end
    end
    chk("accept_seen", got, 1);
    #1;
    if (drop) bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(input int n);
    for (int t = 0; t < 400 && res_n < n; t++) @(posedge clk);
    chk("result_count", res_n, n);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.gate_in = '0; bus.c_in = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_h_out", bus.h_out, 0);
    chk("rst_c_out", bus.c_out, 0);
    chk("rst_mem_net1", mem_net1, 0);
    chk("rst_sel", {gsel, tsel}, 0);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("idle_in_ready", bus.in_ready, 1);

    // zero gates: c = 0.5*1.0 = 0x0080, h = 0.5*0.5 = 0x0040
    send(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 1);
    wait_res(1);
    chk("lit_c_zero", last_c, 16'h0080);
    chk("lit_h_zero", last_h, 16'h0040);
    chk("lit_latency", last_lat, 14);

    // saturated gates with a 5-cycle stall in OUT
    bus.out_ready = 1'b0;
    send(16'h0400, 16'h0200, 16'h0080, 16'h0000, 16'h0100, 1);
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      if (bus.out_valid) break;
    end
    repeat (5) @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_res(2);
    chk("stall_cycles", last_stall, 6);
    chk("lit_c_sat", last_c, 16'h0180);
    chk("lit_h_sat", last_h, 16'h0080);

    // negative values
    send(16'hFC00, 16'h0000, 16'hFF00, 16'h0100, 16'h1234, 1);
    wait_res(3);
    chk("lit_c_neg", last_c, 16'hFF80);
    chk("lit_h_neg", last_h, 16'hFFA0);

    // reset at cycle 5 of an element
    send(16'h0100, 16'h0200, 16'h0300, 16'h0040, 16'h0055, 1);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_accum_rst", accum_rst, 1);
    chk("abort_out_valid", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("abort_no_result", res_n, 3);
    chk("abort_idle_ready", bus.in_ready, 1);
    send(16'h0100, 16'hFF80, 16'h0200, 16'h0300, 16'h0F00, 1);
    wait_res(4);

    // back-to-back with in_valid held high
    send(16'h0040, 16'h0080, 16'hFFC0, 16'h0200, 16'h0200, 0);
    send(16'hFF00, 16'h0300, 16'h0100, 16'hFE00, 16'hFE80, 0);
    send(16'h0010, 16'hFFF0, 16'h0050, 16'h0000, 16'h0333, 1);
    wait_res(7);

`ifdef LSTM_SEQ_LAST_EN
    @(posedge clk); #2 rst = 1'b1;
    repeat (2) @(posedge clk); #2 rst = 1'b0;
    last_mask = '0; n_last = 0;
    for (int e = 0; e < 9; e++)
      send(16'(e * 32), 16'(e * 16), 16'(256 - e * 40), 16'(e * 8), 16'(100 + e), (e == 8));
    wait_res(16);
    chk("last_count", n_last, 2);
    chk("last_positions", last_mask, 32'h0000_0088);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lstm_cell_sequencer.md
Name: lstm_cell_sequencer

Overview:
- Control-and-feed block that drives the LSTM cell datapath's inputs: mem_net1, mem_net2, c_pre, mux_c_gate_sel, mux_c_tanh_sel and accum_rst.
- Accepts one hidden element's four gate pre-activations plus previous cell state. Schedules f*c_pre, i*tanh(g) and o*tanh(c_new) through the shared sigmoid/tanh/mult/accum path.
- Captures h_new/c_new at the correct cycles and returns them on a valid/ready result port.
- Processes one element at a time; sits between the gate-memory reader and the h/c write-back logic.

Parameters:
- WL, 16, word length of all data buses (Q format unchanged, pass-through).
- LAT_ACT, 2, sigmoid/tanh latency in cycles; also the datapath's c_pre delay.
- LAT_MUL, 3, multiplier latency.
- LAT_ACC, 1, accumulator latency (B to Q).
- N_CELL, 32, hidden elements per timestep (used by the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  element request valid
- in_ready  out  1  high only in IDLE
- gate_in  in  4*WL  packed pre-activations {o,g,f,i}, i in LSBs
- c_in  in  WL  previous cell state
- mem_net1  out  WL  to datapath sigmoid input
- mem_net2  out  WL  to datapath tanh input
- c_pre  out  WL  to datapath c_pre
- mux_c_gate_sel  out  1  1 = tanh takes c_new
- mux_c_tanh_sel  out  1  1 = multiplier takes delayed c_pre
- accum_rst  out  1  accumulator clear
- h_new  in  WL  from datapath multiplier output
- c_new  in  WL  from datapath accumulator output
- out_valid  out  1  result valid
- out_ready  in  1  result accepted
- h_out  out  WL  captured hidden output
- c_out  out  WL  captured cell state

Behaviour:
- Reset values: in_ready=0, all datapath data outputs=0, mux selects=0, out_valid=0, h_out=c_out=0, state=IDLE.
- accum_rst = registered clear OR rst, so it is high throughout reset.
- Reset mid-operation aborts the element. No result is emitted, and the held element is discarded.
- Fixed schedule constants: T_C = LAT_ACT+LAT_MUL+LAT_ACC+1, T_H = LAT_ACT+LAT_MUL. Cycle 0 is the FC issue cycle.
- States: IDLE, FC, IG, WAIT_C, OT, WAIT_H, OUT.
- IDLE: in_ready=1. On in_valid, latch gate_in and c_in and go to FC.
- FC (cycle 0, one cycle): mem_net1=f, c_pre=c_in, mux_c_tanh_sel=1, mux_c_gate_sel=0, mem_net2=0.
- IG (cycle 1, one cycle): mem_net1=i, mem_net2=g, mux_c_tanh_sel=0, mux_c_gate_sel=0.
- WAIT_C: runs until cycle T_C-1. A down-counter loaded on FC entry sets the timing.
  - accum_rst=1 for exactly one cycle at cycle T_H-1, so the accumulator sums only the FC and IG products.
  - mem_net1 and mem_net2 are driven 0.
- OT (cycle T_C, one cycle): mem_net1=o, mux_c_gate_sel=1, mux_c_tanh_sel=0. c_out is captured from c_new in this same cycle.
- WAIT_H: h_out is captured from h_new at cycle T_C+T_H, then the block enters OUT.
- OUT: out_valid=1, and h_out/c_out are held stable until out_ready. After acceptance the block returns to IDLE.
  - out_valid and out_ready both high in the same cycle is acceptance.
  - in_ready stays 0 until the next cycle.
- c_pre holds its last driven value outside FC; the datapath's 2-stage delay covers alignment.
- Accumulator contents after OT are don't-care. The next element's accum_rst re-clears them.
- in_valid outside IDLE is ignored. The upstream block must hold in_valid and data until accepted.
- Element latency (accept to out_valid) = T_C+T_H+2 cycles; defaults: 7+5+2 = 14.

Optional Feature:
- Macro: LSTM_SEQ_LAST_EN.
- Defined:
  - Adds output port out_last (1 bit) and a log2(N_CELL)-bit element counter.
  - The counter increments on each result handshake and wraps to 0 after N_CELL-1.
  - out_last=1 alongside out_valid for the result where the counter equals N_CELL-1.
  - Counter resets to 0 on rst.
- Undefined: no port and no counter; all other behaviour identical.

Test Plan:
- Defaults with a cycle-accurate behavioural datapath model. Input i=f=g=o=0, c_in=0x0100, out_ready=1 -> out_valid exactly 14 cycles after accept. c_out=model(0.5*c_in+0.5*tanh(0)), h_out=model(0.5*tanh(c_out)), bit-exact to the model.
- Monitor datapath pins for one element -> accum_rst high only at cycle 4. mux_c_tanh_sel high only at cycle 0. mux_c_gate_sel high only at cycle 7. mem_net1 equals f, i, o at cycles 0, 1, 7 and 0 elsewhere.
- Hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1, h_out/c_out unchanged, in_ready=0. Acceptance on the 6th cycle -> in_ready=1 next cycle.
- Assert rst at cycle 5 of an element -> accum_rst=1 and out_valid=0 immediately; after release the block is in IDLE and the next element result matches the model.
- Back-to-back 3 elements with in_valid held high -> three results, each 14 cycles from its accept, no overlap, no drops.
- With LSTM_SEQ_LAST_EN and N_CELL=4, stream 9 elements -> out_last on results 4 and 8 only.
